// File: rtl/afifo_wr_ingress.sv
// rtl/afifo_wr_ingress.sv - write-side ingress of an async FIFO: skid buffer plus level tracking
//
// Purpose:
//    Accepts an upstream valid/ready beat stream into a 2-entry in-order skid
//    buffer and presents the oldest entry to the write-pointer stage / RAM
//    whenever the FIFO is not full. It also keeps a local binary write count
//    and derives a registered, pessimistic fill level and almost_full flag
//    from the synchronized Gray read pointer.
//
// Ports:
//    wclk          in   write-domain clock
//    wrst_n        in   asynchronous active-low reset
//    s_valid       in   upstream beat valid
//    s_data        in   upstream beat payload
//    s_ready       out  ingress can accept a beat (register-decoded)
//    full          in   registered full flag from the write-pointer stage
//    wg2_rptr      in   Gray read pointer synchronized into wclk
//    w_en          out  write request to the write-pointer stage and RAM
//    w_data        out  RAM write data, valid when w_en=1
//    wlevel        out  registered fill level, write-domain view
//    almost_full   out  registered flag, wlevel >= AFULL_THRESH

module afifo_wr_ingress #(
   parameter int ADDR_WIDTH   = 4,
   parameter int DATA_WIDTH   = 8,
   parameter int AFULL_THRESH = 12
) (
   input  logic                  wclk,
   input  logic                  wrst_n,
   input  logic                  s_valid,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  s_ready,
   input  logic                  full,
   input  logic [ADDR_WIDTH:0]   wg2_rptr,
   output logic                  w_en,
   output logic [DATA_WIDTH-1:0] w_data,
   output logic [ADDR_WIDTH:0]   wlevel,
   output logic                  almost_full
);

   localparam logic [ADDR_WIDTH:0] DEPTH  = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] THRESH = (ADDR_WIDTH+1)'(AFULL_THRESH);

   // buf0 is always the head (oldest) entry, buf1 the one behind it
   logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
   logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
   logic [1:0]            occ_q, occ_d;
   logic [ADDR_WIDTH:0]   wcnt_q, wcnt_d;
   logic [ADDR_WIDTH:0]   wlevel_q, wlevel_d;
   logic                  afull_q, afull_d;

   logic                  accept;
   logic [ADDR_WIDTH:0]   rbin;
   logic [ADDR_WIDTH:0]   diff;

   // Handshake outputs come straight from registered state; w_en only adds
   // the registered full flag, so there is no path from s_valid to s_ready.
   assign s_ready     = (occ_q != 2'd2);
   assign w_en        = (occ_q != 2'd0) && !full;
   assign w_data      = buf0_q;
   assign wlevel      = wlevel_q;
   assign almost_full = afull_q;

   assign accept = s_valid && s_ready;

   always_comb begin
      buf0_d = buf0_q;
      buf1_d = buf1_q;
      occ_d  = occ_q;
      case ({accept, w_en})
         2'b01: begin
            buf0_d = buf1_q;
            occ_d  = occ_q - 2'd1;
         end
         2'b10: begin
            if (occ_q == 2'd0) begin
               buf0_d = s_data;
            end else begin
               buf1_d = s_data;
            end
            occ_d = occ_q + 2'd1;
         end
         2'b11: begin
            // Accept needs occ!=2 and retire needs occ!=0, so occ==1 here:
            // the single head leaves and the new beat becomes the head.
            buf0_d = s_data;
         end
         default: begin
         end
      endcase
   end

   always_comb begin
      rbin = '0;
      for (int i = 0; i <= ADDR_WIDTH; i++) begin
         rbin[i] = ^(wg2_rptr >> i);
      end
      wcnt_d = wcnt_q + {{ADDR_WIDTH{1'b0}}, w_en};
      // Modular subtraction handles pointer wrap; the read pointer can only
      // lag, so the level errs high. Anything past DEPTH is clamped.
      diff     = wcnt_d - rbin;
      wlevel_d = (diff > DEPTH) ? DEPTH : diff;
      afull_d  = (wlevel_d >= THRESH);
   end

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         buf0_q   <= '0;
         buf1_q   <= '0;
         occ_q    <= 2'd0;
         wcnt_q   <= '0;
         wlevel_q <= '0;
         afull_q  <= 1'b0;
      end else begin
         buf0_q   <= buf0_d;
         buf1_q   <= buf1_d;
         occ_q    <= occ_d;
         wcnt_q   <= wcnt_d;
         wlevel_q <= wlevel_d;
         afull_q  <= afull_d;
      end
   end

endmodule

// File: tb/tb_afifo_wr_ingress.sv
// tb/tb_afifo_wr_ingress.sv - self-checking bench for afifo_wr_ingress

module tb_afifo_wr_ingress;

   logic       wclk = 1'b0;
   logic       wrst_n;
   logic       s_valid;
   logic [7:0] s_data;
   logic       s_ready;
   logic       full;
   logic [4:0] wg2_rptr;
   logic       w_en;
   logic [7:0] w_data;
   logic [4:0] wlevel;
   logic       almost_full;

   int n_vec  = 0;
   int n_miss = 0;

   afifo_wr_ingress #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .AFULL_THRESH(12)) dut (
      .wclk        (wclk),
      .wrst_n      (wrst_n),
      .s_valid     (s_valid),
      .s_data      (s_data),
      .s_ready     (s_ready),
      .full        (full),
      .wg2_rptr    (wg2_rptr),
      .w_en        (w_en),
      .w_data      (w_data),
      .wlevel      (wlevel),
      .almost_full (almost_full)
   );

   always #5 wclk = ~wclk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int g2b(input logic [4:0] g);
      int b = 0;
      for (int i = 0; i < 5; i++) begin
         b[i] = ^(g >> i);
      end
      return b;
   endfunction

   function automatic logic [4:0] gray(input int b);
      logic [4:0] v;
      v = 5'(b);
      return v ^ (v >> 1);
   endfunction

   // Model: a queue of beats accepted but not yet written, a total write
   // count, and the registered level/flag seen since the last edge.
   logic [7:0] mq[$];
   int         m_writes = 0;
   int         m_lvl    = 0;
   bit         m_af     = 1'b0;

   always @(negedge wclk) begin
      bit exp_wen;
      bit acc;
      int d;
      if (!wrst_n) begin
         mq.delete();
         m_writes = 0;
         m_lvl    = 0;
         m_af     = 1'b0;
         chk("m_rst_s_ready", s_ready, 1);
         chk("m_rst_w_en", w_en, 0);
         chk("m_rst_wlevel", wlevel, 0);
         chk("m_rst_afull", almost_full, 0);
      end else begin
         exp_wen = (mq.size() > 0) && !full;
         acc     = s_valid && (mq.size() < 2);
         chk("m_s_ready", s_ready, mq.size() < 2);
         chk("m_w_en", w_en, exp_wen);
         if (exp_wen) chk("m_w_data", w_data, mq[0]);
         chk("m_wlevel", wlevel, m_lvl);
         chk("m_afull", almost_full, m_af);
         if (exp_wen) void'(mq.pop_front());
         if (acc) mq.push_back(s_data);
         m_writes = (m_writes + (exp_wen ? 1 : 0)) % 32;
         d = (m_writes - g2b(wg2_rptr) + 32) % 32;
         m_lvl = (d > 16) ? 16 : d;
         m_af  = (m_lvl >= 12);
      end
   end

   task automatic tick;
      @(posedge wclk);
      #1;
   endtask

   task automatic do_reset;
      wrst_n = 1'b0;
      tick();
      tick();
      s_valid = 1'b0;
      full    = 1'b0;
      wrst_n  = 1'b1;
   endtask

   initial begin
      wrst_n   = 1'b0;
      s_valid  = 1'b0;
      s_data   = 8'h00;
      full     = 1'b0;
      wg2_rptr = 5'b0;
      #1;
      chk("rst_s_ready", s_ready, 1);
      chk("rst_w_en", w_en, 0);
      chk("rst_wlevel", wlevel, 0);
      chk("rst_afull", almost_full, 0);
      tick();
      tick();
      wrst_n = 1'b1;

      // single beat latency
      tick();
      s_valid = 1'b1;
      s_data  = 8'hA5;
      tick();
      s_valid = 1'b0;
      chk("lat_w_en", w_en, 1);
      chk("lat_w_data", w_data, 8'hA5);
      tick();
      chk("lat_wlevel", wlevel, 1);
      chk("lat_w_en_off", w_en, 0);

      // backpressure while full
      full    = 1'b1;
      s_valid = 1'b1;
      s_data  = 8'h01;
      tick();
      s_data  = 8'h02;
      tick();
      s_data  = 8'h03;
      chk("bp_s_ready", s_ready, 0);
      chk("bp_w_en", w_en, 0);
      tick();
      tick();
      chk("bp_hold_s_ready", s_ready, 0);
      full = 1'b0;
      #1;
      chk("bp_w_data0", w_data, 8'h01);
      tick();
      chk("bp_w_data1", w_data, 8'h02);
      chk("bp_w_en1", w_en, 1);
      tick();
      s_valid = 1'b0;
      chk("bp_w_data2", w_data, 8'h03);
      chk("bp_w_en2", w_en, 1);
      tick();
      chk("bp_w_en_done", w_en, 0);
      chk("bp_wlevel", wlevel, 4);

      // reset mid-traffic with occ=2 and full=1
      full    = 1'b1;
      s_valid = 1'b1;
      s_data  = 8'h55;
      tick();
      tick();
      chk("mr_pre_s_ready", s_ready, 0);
      wrst_n = 1'b0;
      #1;
      chk("mr_s_ready", s_ready, 1);
      chk("mr_w_en", w_en, 0);
      chk("mr_wlevel", wlevel, 0);
      chk("mr_afull", almost_full, 0);
      full    = 1'b0;
      s_data  = 8'h77;
      tick();
      wrst_n  = 1'b1;
      tick();
      s_valid = 1'b0;
      chk("mr_first_w_en", w_en, 1);
      chk("mr_first_w_data", w_data, 8'h77);
      tick();
      do_reset();

      // almost_full threshold, then read pointer advance
      s_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
         s_data = 8'h20 + 8'(i);
         tick();
      end
      s_valid = 1'b0;
      chk("af_wlevel11", wlevel, 11);
      chk("af_flag11", almost_full, 0);
      tick();
      chk("af_wlevel12", wlevel, 12);
      chk("af_flag12", almost_full, 1);
      wg2_rptr = 5'b00110;
      tick();
      chk("af_wlevel8", wlevel, 8);
      chk("af_flag8", almost_full, 0);

      // pointer wrap: bring write count to 30, read pointer to 29
      wg2_rptr = gray(12);
      s_valid  = 1'b1;
      for (int i = 0; i < 18; i++) begin
         if (i == 9) wg2_rptr = gray(20);
         s_data = 8'h40 + 8'(i);
         tick();
      end
      s_valid  = 1'b0;
      tick();
      wg2_rptr = 5'b10011;
      tick();
      chk("wrap_pre_wlevel", wlevel, 1);
      s_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         s_data = 8'h60 + 8'(i);
         tick();
      end
      s_valid = 1'b0;
      tick();
      chk("wrap_wlevel", wlevel, 4);
      chk("wrap_afull", almost_full, 0);

      // steady streaming at occ=1
      full    = 1'b1;
      s_valid = 1'b1;
      s_data  = 8'h0F;
      tick();
      full    = 1'b0;
      #1;
      chk("st_head", w_data, 8'h0F);
      for (int i = 0; i < 4; i++) begin
         s_data = 8'h10 + 8'(i);
         tick();
         chk("st_w_data", w_data, 8'h10 + 8'(i));
         chk("st_w_en", w_en, 1);
         chk("st_s_ready", s_ready, 1);
      end
      s_valid = 1'b0;
      tick();
      chk("st_drain", w_en, 0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
